// File: rtl/unidade_pc.sv
// Program-counter unit for the multicycle RISC-V datapath: holds PC, EPC, the
// misalignment cause flag and a retired-instruction counter, all committed in the PC-update state.
module unidade_pc #(
  parameter int unsigned               XLEN         = 32,
  parameter int unsigned               IMM_W        = 21,
  parameter int unsigned               STATE_W      = 4,
  parameter logic [STATE_W-1:0]        UPDATE_STATE = 4'b0111,
  parameter int unsigned               BYTE_ADDR    = 0,
  parameter logic [XLEN-1:0]           RESET_PC     = '0,
  parameter logic [XLEN-1:0]           TRAP_VEC     = 'h40,
  parameter int unsigned               CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] estado,
  input  logic               stall,
  input  logic [2:0]         pcsrc,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   immediate,
  input  logic [XLEN-1:0]    rs1,
  output logic [XLEN-1:0]    PC,
  output logic [XLEN-1:0]    pc_ret,
  output logic [XLEN-1:0]    epc,
  output logic               misaligned,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [XLEN-1:0] STEP = (BYTE_ADDR != 0) ? XLEN'(4) : XLEN'(1);

  localparam logic [2:0] SRC_BRANCH = 3'b001;
  localparam logic [2:0] SRC_JAL    = 3'b010;
  localparam logic [2:0] SRC_JALR   = 3'b011;
  localparam logic [2:0] SRC_TRAP   = 3'b100;
  localparam logic [2:0] SRC_TRET   = 3'b101;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic             commit;
  logic [XLEN-1:0]  off, relOff, relTarget, seqTarget;
  logic [XLEN-1:0]  jalrSum, jalrT, jalrTarget;
  logic             relMis, jalrMis;

  assign commit    = (estado == UPDATE_STATE) && !stall;
  assign off       = {{(XLEN-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign seqTarget = pc_q + STEP;

  // Word-addressed PCs count instructions, so byte offsets are scaled down (arithmetically).
  assign relOff    = (BYTE_ADDR != 0) ? off : {{2{off[XLEN-1]}}, off[XLEN-1:2]};
  assign relTarget = pc_q + relOff;
  assign relMis    = (BYTE_ADDR != 0) ? (relTarget[1:0] != 2'b00) : (off[1:0] != 2'b00);

  assign jalrSum    = rs1 + off;
  assign jalrT      = jalrSum & ~XLEN'(1);
  assign jalrTarget = (BYTE_ADDR != 0) ? jalrT : {2'b00, jalrT[XLEN-1:2]};
  assign jalrMis    = (BYTE_ADDR != 0) ? (jalrT[1:0] != 2'b00) : jalrT[1];

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    mis_d = mis_q;
    ret_d = ret_q;
    if (commit) begin
      ret_d = ret_q + CNT_W'(1);
      pc_d  = seqTarget;
      unique case (pcsrc)
        SRC_BRANCH: begin
          if (branch_taken) begin
            if (relMis) begin
              pc_d  = TRAP_VEC;
              epc_d = pc_q;
              mis_d = 1'b1;
            end else begin
              pc_d = relTarget;
            end
          end
        end
        SRC_JAL: begin
          if (relMis) begin
            pc_d  = TRAP_VEC;
            epc_d = pc_q;
            mis_d = 1'b1;
          end else begin
            pc_d = relTarget;
          end
        end
        SRC_JALR: begin
          if (jalrMis) begin
            pc_d  = TRAP_VEC;
            epc_d = pc_q;
            mis_d = 1'b1;
          end else begin
            pc_d = jalrTarget;
          end
        end
        SRC_TRAP: begin
          pc_d  = TRAP_VEC;
          epc_d = pc_q;
          mis_d = 1'b0;
        end
        SRC_TRET: begin
          pc_d  = epc_q;
          mis_d = 1'b0;
        end
        default: pc_d = seqTarget;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
      mis_q <= 1'b0;
      ret_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
      ret_q <= ret_d;
    end
  end

  assign PC         = pc_q;
  assign pc_ret     = seqTarget;
  assign epc        = epc_q;
  assign misaligned = mis_q;
  assign retired    = ret_q;

endmodule
